// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_pkg
// Brief  : Shared pipeline definitions: hazard FSM encoding and register
//          index width.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

   // Width of an architectural register index (x0..x31)
   localparam int REG_IDX_W = 5;

   // Hazard controller states
   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module : load_use_detect
// Brief  : Purely combinational load-use hazard detector. Flags when the
//          instruction in ID reads the destination of a load sitting in EX.
//          Writes to x0 never create a dependency.
// Rev    : 1.0  initial release
// ============================================================================
module load_use_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 idex_mem_read,
   input  logic [REG_IDX_W-1:0] idex_rd,
   output logic                 hazard
);

   logic rs1_match;
   logic rs2_match;
   logic rd_nonzero;

   // Compare both ID sources against the EX load destination
   always_comb begin
      rs1_match  = id_uses_rs1 && (id_rs1 == idex_rd);
      rs2_match  = id_uses_rs2 && (id_rs2 == idex_rd);
      rd_nonzero = (idex_rd != '0);
      hazard     = idex_mem_read && rd_nonzero && (rs1_match || rs2_match);
   end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Pipeline hazard controller. Stalls the pipe while data memory is
//          busy (with timeout abort), flushes on taken branches and inserts a
//          one-cycle bubble on load-use dependencies. Priority is
//          memory stall > branch flush > load-use stall.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] IDRs1,
   input  logic [REG_IDX_W-1:0] IDRs2,
   input  logic                 IDUsesRs1,
   input  logic                 IDUsesRs2,
   input  logic                 IDEXMemRead,
   input  logic [REG_IDX_W-1:0] IDEXRegRd,
   input  logic                 EXBranchTaken,
   input  logic                 EXMEMMemRead,
   input  logic                 EXMEMMemWrite,
   input  logic                 MemReady,
   output logic                 MemReq,
   output logic                 PCStall,
   output logic                 IFIDStall,
   output logic                 IDEXStall,
   output logic                 EXMEMStall,
   output logic                 IFIDFlush,
   output logic                 IDEXFlush,
   output logic                 MEMWBFlush,
   output logic                 MemErr,
   output logic [15:0]          StallCycles
);

   // Wait counter only has to reach MEM_TIMEOUT; keep it at least 1 bit wide
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
   localparam logic [15:0]      STALL_MAX   = 16'hFFFF;

   hz_state_t        state;
   logic [CNT_W-1:0] wait_cnt;

   logic mem_access;
   logic timeout_hit;
   logic mem_stall;
   logic load_use;
   logic branch_flush;
   logic lu_stall;

   load_use_detect u_load_use_detect (
      .id_rs1        (IDRs1),
      .id_rs2        (IDRs2),
      .id_uses_rs1   (IDUsesRs1),
      .id_uses_rs2   (IDUsesRs2),
      .idex_mem_read (IDEXMemRead),
      .idex_rd       (IDEXRegRd),
      .hazard        (load_use)
   );

   // Resolve memory stall, then branch and load-use in priority order
   always_comb begin
      mem_access  = EXMEMMemRead || EXMEMMemWrite;
      timeout_hit = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_VAL);
      case (state)
         RUN:      mem_stall = mem_access && !MemReady;
         MEM_WAIT: mem_stall = !MemReady && !timeout_hit;
         default:  mem_stall = 1'b0;
      endcase
      // EX and ID are frozen during a memory stall, so these are simply
      // re-evaluated once the stall lets go
      branch_flush = EXBranchTaken && !mem_stall;
      lu_stall     = load_use && !mem_stall && !EXBranchTaken;

      // Reset forces every control output quiet
      MemReq     = !rst && mem_access;
      PCStall    = !rst && (mem_stall || lu_stall);
      IFIDStall  = !rst && (mem_stall || lu_stall);
      IDEXStall  = !rst && mem_stall;
      EXMEMStall = !rst && mem_stall;
      MEMWBFlush = !rst && mem_stall;
      IFIDFlush  = !rst && branch_flush;
      IDEXFlush  = !rst && (branch_flush || lu_stall);
   end

   // Memory-wait FSM, timeout abort, sticky error and stall statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         MemErr      <= 1'b0;
         StallCycles <= '0;
      end else begin
         if (mem_stall && (StallCycles != STALL_MAX)) begin
            StallCycles <= StallCycles + 16'd1;
         end
         case (state)
            RUN: begin
               if (mem_access && !MemReady) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (MemReady) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (timeout_hit) begin
                  state    <= RUN;
                  wait_cnt <= '0;
                  MemErr   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
//          Inputs change 1ns after the rising edge; outputs are checked at
//          the falling edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  IDRs1, IDRs2, IDEXRegRd;
   logic        IDUsesRs1, IDUsesRs2, IDEXMemRead, EXBranchTaken;
   logic        EXMEMMemRead, EXMEMMemWrite, MemReady;
   logic        MemReq, PCStall, IFIDStall, IDEXStall, EXMEMStall;
   logic        IFIDFlush, IDEXFlush, MEMWBFlush, MemErr;
   logic [15:0] StallCycles;
   logic [7:0]  outs;

   int errors = 0;
   int checks = 0;

   // Output vector bit map:
   // [7]PCStall [6]IFIDStall [5]IDEXStall [4]EXMEMStall
   // [3]IFIDFlush [2]IDEXFlush [1]MEMWBFlush [0]MemReq
   localparam logic [7:0] O_IDLE = 8'h00;
   localparam logic [7:0] O_MSTL = 8'hF3;  // memory stall with access
   localparam logic [7:0] O_MREQ = 8'h01;  // access, no stall
   localparam logic [7:0] O_LU   = 8'hC4;  // load-use bubble
   localparam logic [7:0] O_BR   = 8'h0C;  // branch flush
   localparam logic [7:0] O_BRMQ = 8'h0D;  // branch flush with access

   assign outs = {PCStall, IFIDStall, IDEXStall, EXMEMStall,
                  IFIDFlush, IDEXFlush, MEMWBFlush, MemReq};

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .IDRs1         (IDRs1),
      .IDRs2         (IDRs2),
      .IDUsesRs1     (IDUsesRs1),
      .IDUsesRs2     (IDUsesRs2),
      .IDEXMemRead   (IDEXMemRead),
      .IDEXRegRd     (IDEXRegRd),
      .EXBranchTaken (EXBranchTaken),
      .EXMEMMemRead  (EXMEMMemRead),
      .EXMEMMemWrite (EXMEMMemWrite),
      .MemReady      (MemReady),
      .MemReq        (MemReq),
      .PCStall       (PCStall),
      .IFIDStall     (IFIDStall),
      .IDEXStall     (IDEXStall),
      .EXMEMStall    (EXMEMStall),
      .IFIDFlush     (IFIDFlush),
      .IDEXFlush     (IDEXFlush),
      .MEMWBFlush    (MEMWBFlush),
      .MemErr        (MemErr),
      .StallCycles   (StallCycles)
   );

   // 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge (input drive point)
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   // Move to the falling edge of the current cycle (check point)
   task automatic mid;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      IDRs1 = '0; IDRs2 = '0; IDEXRegRd = '0;
      IDUsesRs1 = 1'b0; IDUsesRs2 = 1'b0; IDEXMemRead = 1'b0;
      EXBranchTaken = 1'b0; EXMEMMemRead = 1'b0; EXMEMMemWrite = 1'b0;
      MemReady = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      // Access pending while in reset must stay silent
      EXMEMMemRead = 1'b1;
      mid();
      chk("rst_outs_quiet", {8'h0, outs}, {8'h0, O_IDLE});
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      mid();
      chk("reset_outs", {8'h0, outs}, {8'h0, O_IDLE});
      chk("reset_memerr", {15'h0, MemErr}, 16'h0);
      chk("reset_stallcycles", StallCycles, 16'd0);

      // Load-use on Rs1
      next_cycle();
      IDEXMemRead = 1'b1; IDEXRegRd = 5'd5; IDRs1 = 5'd5; IDUsesRs1 = 1'b1;
      mid();
      chk("lu_rs1", {8'h0, outs}, {8'h0, O_LU});
      next_cycle();
      idle_inputs();
      mid();
      chk("lu_rs1_cleared", {8'h0, outs}, {8'h0, O_IDLE});

      // Load-use on Rs2, then the same registers with the read flag off
      next_cycle();
      IDEXMemRead = 1'b1; IDEXRegRd = 5'd7; IDRs1 = 5'd3; IDRs2 = 5'd7;
      IDUsesRs1 = 1'b1; IDUsesRs2 = 1'b1;
      mid();
      chk("lu_rs2", {8'h0, outs}, {8'h0, O_LU});
      next_cycle();
      IDUsesRs2 = 1'b0;
      mid();
      chk("lu_rs2_unused", {8'h0, outs}, {8'h0, O_IDLE});

      // x0 destination never creates a hazard
      next_cycle();
      idle_inputs();
      IDEXMemRead = 1'b1; IDEXRegRd = 5'd0; IDRs1 = 5'd0; IDUsesRs1 = 1'b1;
      mid();
      chk("lu_x0_guard", {8'h0, outs}, {8'h0, O_IDLE});

      // Branch alone, then branch together with load-use
      next_cycle();
      idle_inputs();
      EXBranchTaken = 1'b1;
      mid();
      chk("branch", {8'h0, outs}, {8'h0, O_BR});
      next_cycle();
      IDEXMemRead = 1'b1; IDEXRegRd = 5'd9; IDRs1 = 5'd9; IDUsesRs1 = 1'b1;
      mid();
      chk("branch_plus_lu", {8'h0, outs}, {8'h0, O_BR});

      // Zero-wait access, then idle with MemReady low proves still in RUN
      next_cycle();
      idle_inputs();
      EXMEMMemRead = 1'b1; MemReady = 1'b1;
      mid();
      chk("zero_wait_access", {8'h0, outs}, {8'h0, O_MREQ});
      next_cycle();
      idle_inputs();
      mid();
      chk("zero_wait_stays_run", {8'h0, outs}, {8'h0, O_IDLE});
      chk("zero_wait_no_count", StallCycles, 16'd0);

      // Three-cycle memory wait; branch and load-use held off meanwhile
      next_cycle();
      EXMEMMemRead = 1'b1; MemReady = 1'b0;
      mid();
      chk("mwait_c1", {8'h0, outs}, {8'h0, O_MSTL});
      next_cycle();
      EXBranchTaken = 1'b1;
      mid();
      chk("mwait_c2_branch_held", {8'h0, outs}, {8'h0, O_MSTL});
      next_cycle();
      IDEXMemRead = 1'b1; IDEXRegRd = 5'd4; IDRs2 = 5'd4; IDUsesRs2 = 1'b1;
      mid();
      chk("mwait_c3_lu_held", {8'h0, outs}, {8'h0, O_MSTL});
      next_cycle();
      MemReady = 1'b1;
      mid();
      chk("mwait_ready_branch", {8'h0, outs}, {8'h0, O_BRMQ});
      next_cycle();
      idle_inputs();
      mid();
      chk("mwait_back_to_run", {8'h0, outs}, {8'h0, O_IDLE});
      chk("mwait_stallcycles", StallCycles, 16'd3);
      chk("mwait_no_err", {15'h0, MemErr}, 16'h0);

      // Store that never completes: 4 stalled cycles, then abort
      next_cycle();
      EXMEMMemWrite = 1'b1; MemReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk($sformatf("tmo_stall_%0d", i), {8'h0, outs}, {8'h0, O_MSTL});
         next_cycle();
      end
      mid();
      chk("tmo_release", {8'h0, outs}, {8'h0, O_MREQ});
      chk("tmo_err_not_yet", {15'h0, MemErr}, 16'h0);
      next_cycle();
      idle_inputs();
      mid();
      chk("tmo_memerr_set", {15'h0, MemErr}, 16'h1);
      chk("tmo_run_idle", {8'h0, outs}, {8'h0, O_IDLE});
      chk("tmo_stallcycles", StallCycles, 16'd7);
      next_cycle();
      next_cycle();
      mid();
      chk("tmo_memerr_sticky", {15'h0, MemErr}, 16'h1);

      // Reset in the middle of a memory wait
      next_cycle();
      EXMEMMemRead = 1'b1; MemReady = 1'b0;
      mid();
      chk("rstwait_stall", {8'h0, outs}, {8'h0, O_MSTL});
      next_cycle();
      rst = 1'b1;
      mid();
      chk("rstwait_outs_quiet", {8'h0, outs}, {8'h0, O_IDLE});
      chk("rstwait_count_before", StallCycles, 16'd8);
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      mid();
      chk("rstwait_outs_run", {8'h0, outs}, {8'h0, O_IDLE});
      chk("rstwait_memerr", {15'h0, MemErr}, 16'h0);
      chk("rstwait_stallcycles", StallCycles, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before abort.
REQ-002 Ports, name direction width meaning:
- clk in 1: clock; state updates on rising edge, so stall/flush are stable before the pipeline registers' falling-edge capture.
- rst in 1: reset, synchronous, active-high.
- IDRs1, IDRs2 in 5: source registers of the instruction in ID.
- IDUsesRs1, IDUsesRs2 in 1: ID instruction reads Rs1/Rs2.
- IDEXMemRead in 1: instruction in EX is a load.
- IDEXRegRd in 5: destination of the EX instruction.
- EXBranchTaken in 1: EX resolves a taken branch/jump.
- EXMEMMemRead, EXMEMMemWrite in 1: MEM-stage access pending.
- MemReady in 1: data memory completes access this cycle.
- MemReq out 1: data memory request.
- PCStall, IFIDStall, IDEXStall, EXMEMStall out 1: hold the register.
- IFIDFlush, IDEXFlush, MEMWBFlush out 1: load bubble.
- MemErr out 1: sticky timeout flag.
- StallCycles out 16: saturating count of memory-stall cycles.

Function
REQ-003 FSM states: RUN, MEM_WAIT; the reset state is RUN.
REQ-004 MemReq is 1 whenever EXMEMMemRead or EXMEMMemWrite is 1, in either state.
REQ-005 RUN with access and MemReady=0: assert PCStall, IFIDStall, IDEXStall, EXMEMStall, MEMWBFlush; next state MEM_WAIT.
REQ-006 RUN with access and MemReady=1: zero-wait access; no memory stall; stay in RUN.
REQ-007 MEM_WAIT with MemReady=0: assert the same stall set as REQ-005; the wait counter increments.
REQ-008 MEM_WAIT with MemReady=1: deassert the memory stalls in the same cycle; clear the wait counter; next state RUN.
REQ-009 Wait counter reaching MEM_TIMEOUT: set MemErr to 1 (sticky until rst); release the stalls in that cycle; next state RUN.
REQ-010 Load-use hazard is all of the following:
- IDEXMemRead=1;
- IDEXRegRd!=0;
- (IDUsesRs1 and IDRs1==IDEXRegRd) or (IDUsesRs2 and IDRs2==IDEXRegRd).
REQ-011 Load-use with no memory stall: assert PCStall, IFIDStall, IDEXFlush for exactly that cycle.
REQ-012 EXBranchTaken with no memory stall: assert IFIDFlush and IDEXFlush.
REQ-013 Priority is memory stall > branch flush > load-use stall:
- during a memory stall, the branch and load-use outputs are suppressed;
- they are re-evaluated once the stall releases, because EX and ID are held.
REQ-014 Branch and load-use in the same cycle: branch flush only; PCStall and IFIDStall stay 0.
REQ-015 All stall/flush/MemReq outputs are combinational from state and inputs; MemErr, StallCycles and the FSM are registered.
REQ-016 StallCycles increments by 1 on every cycle in which the REQ-005/007 stalls are asserted, and saturates at 16'hFFFF.
REQ-017 With no access, branch or hazard, all stall/flush outputs are 0.

Reset
REQ-018 On rst=1 at a rising edge:
- state becomes RUN;
- wait counter becomes 0;
- MemErr becomes 0;
- StallCycles becomes 0.
REQ-019 rst mid-MEM_WAIT abandons the wait; while rst=1, all stall/flush outputs and MemReq are 0.

Structure
REQ-020 A shared pipeline package holds the state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the register-index width 5.
REQ-021 Load-use comparison is a natural sub-module, load_use_detect (purely combinational); everything else stays flat.

Verification
REQ-022 Load-use: IDEXMemRead=1, IDEXRegRd=5, IDRs1=5, IDUsesRs1=1 -> one cycle of PCStall=IFIDStall=IDEXFlush=1; 0 the next cycle once the inputs clear.
REQ-023 x0 guard: same as REQ-022 with IDEXRegRd=0 and IDRs1=0 -> no stall.
REQ-024 Memory wait: EXMEMMemRead=1, MemReady low for 3 cycles then high:
- stalls and MEMWBFlush asserted for 3 cycles, deasserted on the ready cycle;
- StallCycles=3;
- state back to RUN.
REQ-025 Priority: EXBranchTaken=1 during MEM_WAIT -> no IFIDFlush; flush appears on the cycle MemReady=1. Branch plus load-use in RUN -> IFIDFlush=IDEXFlush=1, PCStall=0.
REQ-026 Timeout: MEM_TIMEOUT=4, MemReady held 0:
- MemErr=1 after 4 wait cycles;
- stalls released;
- MemErr stays 1 until rst.
REQ-027 Reset: rst asserted in MEM_WAIT -> next cycle state RUN, MemErr=0, StallCycles=0, all outputs 0.
